// File: rtl/serial_sub_ctrl_pkg.sv
// rtl/serial_sub_ctrl_pkg.sv - shared state encoding and nibble width for the serial subtractor
package serial_sub_ctrl_pkg;

    localparam int NIB_W = 4;

    // 2'd3 is unused; the controller falls back to ST_IDLE if it is ever seen
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sub_bin.sv
// rtl/nibble_sub_bin.sv - combinational 4-bit subtract-with-borrow stage
module nibble_sub_bin
    import serial_sub_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);

    logic [NIB_W:0] full;

    // One extra bit catches the sign of a - b - bin, which is exactly the borrow-out
    assign full = {1'b0, a} - {1'b0, b} - {{NIB_W{1'b0}}, bin};
    assign d    = full[NIB_W-1:0];
    assign bout = full[NIB_W];

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - sequences one shared nibble subtractor over WIDTH-bit operands, LSB first
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NNIB = WIDTH / NIB_W;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NNIB - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             bin_q;
    logic             borrow_q;
    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] d_nib;
    logic             bout;
    logic             accept;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid & in_ready;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

    assign a_nib = a_q[cnt*NIB_W +: NIB_W];
    assign b_nib = b_q[cnt*NIB_W +: NIB_W];

    nibble_sub_bin u_nib (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (bin_q),
        .d    (d_nib),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)          state_nx = ST_RUN;
            ST_RUN:  if (cnt == LAST_NIB) state_nx = ST_DONE;
            ST_DONE: if (out_ready)       state_nx = ST_IDLE;
            default:                      state_nx = ST_IDLE;
        endcase
    end

    // Operands and result are only touched on accept and during RUN, so DONE holds them stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                diff_q   <= '0;
                cnt      <= '0;
                bin_q    <= 1'b0;
                borrow_q <= 1'b0;
            end
        end else if (state == ST_RUN) begin
            diff_q[cnt*NIB_W +: NIB_W] <= d_nib;
            bin_q                      <= bout;
            if (cnt == LAST_NIB) begin
                cnt      <= '0;
                borrow_q <= bout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - scoreboard bench for serial_sub_ctrl at WIDTH=16 and WIDTH=4
module tb_serial_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        borrow;

    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [3:0]  diff4;
    logic        borrow4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issued = 0;
    int done_cnt = 0;

    logic [16:0] exp_q[$];
    int          acc_q[$];
    logic [16:0] held;
    bit          in_done = 1'b0;

    serial_sub_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow(borrow)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrow(borrow4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic and unsigned compare
    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        logic r;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            a = av; b = bv; in_valid = 1'b1;
            r = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!r && n < 200);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        if (!r) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back({(av < bv), 16'(av - bv)});
            acc_q.push_back(cyc);
            issued++;
        end
    endtask

    task automatic wait_idle(input bit rnd);
        int n;
        for (n = 0; n < 200; n++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (in_ready) break;
        end
        if (n == 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        logic [16:0] e;
        int          ac;
        if (rst_n) begin
            if (out_valid) begin
                if (!in_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        ac = acc_q.pop_front();
                        check("diff", 32'(diff), 32'(e[15:0]));
                        check("borrow", 32'(borrow), 32'(e[16]));
                        check("latency", 32'(cyc - ac), 32'd4);
                        done_cnt++;
                    end
                    held    = {borrow, diff};
                    in_done = 1'b1;
                end else begin
                    check("hold_stable", 32'({borrow, diff}), 32'(held));
                end
                check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) in_done = 1'b0;
            end else begin
                in_done = 1'b0;
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        ir, ov;
        int          prev, last_acc, n4;

        repeat (2) @(posedge clk);
        #1;
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd1);

        out_ready = 1'b1;
        issue(16'h1234, 16'h0234);
        wait_idle(1'b0);
        issue(16'h0000, 16'h0001);
        wait_idle(1'b0);
        issue(16'hABCD, 16'hABCD);
        wait_idle(1'b0);

        // Backpressure in DONE
        out_ready = 1'b0;
        issue(16'h3000, 16'h4001);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_reached_done", 32'(out_valid), 32'd1);
        repeat (6) begin
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);

        // in_valid during RUN must be ignored
        issue(16'h5678, 16'h1234);
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle(1'b0);

        // Reset mid-RUN after nibble 1
        issue(16'hFFFF, 16'h0000);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        issued--;
        #1;
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_borrow", 32'(borrow), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        issue(16'h8000, 16'h7FFF);
        wait_idle(1'b0);

        // Randomized ops with random backpressure
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: begin ra = 16'h0000; rb = 16'($urandom_range(1, 65535)); end
                2: begin ra = 16'hFFFF; end
                default: ;
            endcase
            issue(ra, rb);
            wait_idle(1'b1);
        end
        out_ready = 1'b1;

        // WIDTH=4: continuous requests, 1-edge latency, ops spaced 3 cycles
        in_valid4 = 1'b1; a4 = 4'h3; b4 = 4'h5; out_ready4 = 1'b1;
        prev = -1; last_acc = -100; n4 = 0;
        repeat (10) begin
            @(negedge clk);
            ir = in_ready4;
            ov = out_valid4;
            if (ov) begin
                check("w4_diff", 32'(diff4), 32'hE);
                check("w4_borrow", 32'(borrow4), 32'd1);
                check("w4_latency", 32'(cyc - last_acc), 32'd1);
            end
            @(posedge clk); #1;
            if (ir) begin
                if (prev >= 0) check("w4_spacing", 32'(cyc - prev), 32'd3);
                prev = cyc;
                last_acc = cyc;
                n4++;
            end
        end
        in_valid4 = 1'b0;
        check("w4_accepts", 32'(n4 >= 3), 32'd1);

        repeat (10) @(posedge clk);
        #1;
        check("drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
